retire_trace_gen: RTL and testbench
===================================

RETIRE_TRACE_GEN -- requirements
Module: retire_trace_gen

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered retire records; legal values are powers of two, 4 to 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; it is synchronous and active-high.
REQ-004 SHALL have port wb_a_valid  input  1  primary writeback-stage retire event this cycle.
REQ-005 SHALL have ports wb_a_pc  input  32, wb_a_waddr  input  5, wb_a_wdata  input  32, carrying the PC, destination register and write data of the source-A event.
REQ-006 SHALL have port wb_b_valid  input  1  secondary (long-latency unit) retire event this cycle.
REQ-007 SHALL have ports wb_b_pc  input  32, wb_b_waddr  input  5, wb_b_wdata  input  32, carrying the PC, destination register and write data of the source-B event.
REQ-008 SHALL have port inst_retire  output  70  retire record with fields [31:0] pc, [63:32] rf_wdata, [68:64] rf_waddr, [69] rf_en.
REQ-009 SHALL have port retire_stall  output  1  asks the pipeline to hold further retires.
REQ-010 SHALL have port overflow_err  output  1  sticky flag: a record was lost.

Function
REQ-011 SHALL accept an event only if its valid bit is 1 and its waddr is not 0; any other event is dropped silently and raises no error.
REQ-012 SHALL order accepted events within one cycle as A first, then B.
REQ-013 SHALL register inst_retire, presenting at most one record per cycle with rf_en=1 for exactly one cycle.
REQ-014 SHALL, each cycle the FIFO is non-empty, load the oldest FIFO entry into inst_retire on the next edge and push all accepted events into the FIFO in order.
REQ-015 SHALL, when the FIFO is empty, bypass the first accepted event into inst_retire on the next edge (one-cycle latency) and push the second accepted event, if any, into the FIFO.
REQ-016 SHALL drive inst_retire to all zeros (rf_en=0) when there is no FIFO entry and no accepted event.
REQ-017 SHALL compute FIFO occupancy per cycle as count_next = count + pushes - pops, with pushes in 0..2 and pops in 0..1.
REQ-018 SHALL handle simultaneous pop and push on a full FIFO as legal: the pop frees space first, then pushes fill it.
REQ-019 SHALL use wrap-around pointers of width log2(FIFO_DEPTH) plus one wrap bit.
REQ-020 SHALL assert retire_stall combinationally from the registered count when count >= FIFO_DEPTH-1, i.e. when fewer than 2 entries are free.
REQ-021 SHALL, on overflow (pushes exceeding free space after the pop), drop excess records B first, keep all stored records intact, and set overflow_err on the next edge; overflow_err then holds until rst.
REQ-022 SHALL never reorder, duplicate or drop accepted records except as stated in REQ-021.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, clear count and both pointers, set inst_retire to 0 and overflow_err to 0, so that retire_stall is 0.
REQ-024 SHALL discard all buffered records on a reset asserted mid-operation, with no record emitted in the first cycle after reset.
REQ-025 SHALL ignore inputs during any cycle in which rst=1.

Configuration
REQ-026 SHALL use macro RETIRE_TRACE_EN; when it is defined, the full behaviour above applies.
REQ-027 SHALL, when RETIRE_TRACE_EN is not defined, instantiate no FIFO, tie inst_retire, retire_stall and overflow_err to constant 0, and leave the inputs unused.

Structure
REQ-028 SHALL place the shared package contents in retire_trace_pkg: RETIRE_W=70, the field offsets PC_LSB=0, WDATA_LSB=32, WADDR_LSB=64, EN_BIT=69, and a packed retire record typedef.
REQ-029 SHALL contain one sub-module, retire_fifo, a synchronous FIFO with two write ports (ordered) and one read port, exposing count.
REQ-030 SHALL keep the bypass, filtering, stall and error logic in retire_trace_gen.

Verification
REQ-031 SHALL cover: A valid, pc=0x00000010, waddr=5, wdata=0xDEADBEEF, FIFO empty -> next cycle inst_retire = {1, 5, 0xDEADBEEF, 0x10}, then 0 on the cycle after.
REQ-032 SHALL cover: A (waddr=1, pc=0x20) and B (waddr=2, pc=0x24) in the same cycle -> pc 0x20 emitted at N+1, pc 0x24 at N+2.
REQ-033 SHALL cover: A valid with waddr=0, B invalid -> inst_retire stays 0 and overflow_err stays 0.
REQ-034 SHALL cover: FIFO_DEPTH=4 with dual events every cycle -> retire_stall=1 once count reaches 3; continuing while stalled -> overflow_err=1 and only B records are lost.
REQ-035 SHALL cover: rst pulsed for one cycle while 3 records are buffered -> count=0, inst_retire=0 for the following cycles, and no stale record appears.
REQ-036 SHALL cover: a build without RETIRE_TRACE_EN driven by random events -> all outputs constant 0.

Source files
------------

// File: rtl/retire_trace_pkg.sv
// -----------------------------------------------------------------------------
// retire_trace_pkg
// Shared definitions for the retire trace generator: record width, field
// offsets inside the 70-bit retire record, the packed record type and a
// helper that builds a valid record from writeback fields.
// Record layout: [31:0] pc, [63:32] rf_wdata, [68:64] rf_waddr, [69] rf_en.
// -----------------------------------------------------------------------------
package retire_trace_pkg;

   localparam int RETIRE_W  = 70;
   localparam int PC_LSB    = 0;
   localparam int WDATA_LSB = 32;
   localparam int WADDR_LSB = 64;
   localparam int EN_BIT    = 69;

   typedef struct packed {
      logic        rf_en;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [31:0] pc;
   } retire_rec_t;

   // Builds a record with rf_en set, placing each field at its declared offset.
   function automatic retire_rec_t make_rec(input logic [31:0] pc,
                                            input logic [4:0]  waddr,
                                            input logic [31:0] wdata);
      logic [RETIRE_W-1:0] r;
      r                     = {RETIRE_W{1'b0}};
      r[PC_LSB +: 32]       = pc;
      r[WDATA_LSB +: 32]    = wdata;
      r[WADDR_LSB +: 5]     = waddr;
      r[EN_BIT]             = 1'b1;
      return retire_rec_t'(r);
   endfunction

endpackage

// File: rtl/retire_fifo.sv
// -----------------------------------------------------------------------------
// retire_fifo
// Synchronous FIFO of retire records with two ordered write ports and one
// read port. Port 0 is written before port 1 in the same cycle. The caller
// guarantees writes never exceed free space (after the same-cycle pop).
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr0_en_i / wr0_data_i first write of the cycle
//   wr1_en_i / wr1_data_i second write of the cycle (only with wr0_en_i)
//   rd_en_i               pop the head entry
//   rd_data_o             head entry (valid when count_o != 0)
//   count_o               occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module retire_fifo
   import retire_trace_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr0_en_i,
   input  retire_rec_t      wr0_data_i,
   input  logic             wr1_en_i,
   input  retire_rec_t      wr1_data_i,
   input  logic             rd_en_i,
   output retire_rec_t      rd_data_o,
   output logic [PTR_W:0]   count_o
);

   retire_rec_t      mem_q [DEPTH];
   logic [PTR_W:0]   wptr_q, wptr_d;
   logic [PTR_W:0]   rptr_q, rptr_d;
   logic [PTR_W-1:0] widx0_s, widx1_s;

   // Next pointers; the second write lands just after the first one.
   always_comb begin
      widx0_s = wptr_q[PTR_W-1:0];
      widx1_s = wptr_q[PTR_W-1:0] + {{(PTR_W-1){1'b0}}, wr0_en_i};
      wptr_d  = wptr_q + {{PTR_W{1'b0}}, wr0_en_i} + {{PTR_W{1'b0}}, wr1_en_i};
      rptr_d  = rptr_q + {{PTR_W{1'b0}}, rd_en_i};
   end

   // Pointer registers; the extra wrap bit distinguishes full from empty.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= {(PTR_W+1){1'b0}};
         rptr_q <= {(PTR_W+1){1'b0}};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array; nothing is written while in reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (wr0_en_i) mem_q[widx0_s] <= wr0_data_i;
         if (wr1_en_i) mem_q[widx1_s] <= wr1_data_i;
      end
   end

   assign rd_data_o = mem_q[rptr_q[PTR_W-1:0]];
   assign count_o   = wptr_q - rptr_q;

endmodule

// File: rtl/retire_trace_gen.sv
// -----------------------------------------------------------------------------
// retire_trace_gen
// Merges two writeback retire sources (A primary, B long-latency) into a
// single registered retire trace, one record per cycle, buffering extras in
// retire_fifo. Events with valid=0 or waddr=0 are dropped silently.
// Configuration macro: RETIRE_TRACE_EN. When undefined, no FIFO is built and
// all outputs are constant 0.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wb_a_valid/pc/waddr/wdata    source A retire event
//   wb_b_valid/pc/waddr/wdata    source B retire event
//   inst_retire                  registered retire record (rf_en in bit 69)
//   retire_stall                 fewer than two FIFO entries free
//   overflow_err                 sticky: a record was dropped for lack of space
// -----------------------------------------------------------------------------
module retire_trace_gen
   import retire_trace_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_a_valid,
   input  logic [31:0]         wb_a_pc,
   input  logic [4:0]          wb_a_waddr,
   input  logic [31:0]         wb_a_wdata,
   input  logic                wb_b_valid,
   input  logic [31:0]         wb_b_pc,
   input  logic [4:0]          wb_b_waddr,
   input  logic [31:0]         wb_b_wdata,
   output logic [RETIRE_W-1:0] inst_retire,
   output logic                retire_stall,
   output logic                overflow_err
);

`ifdef RETIRE_TRACE_EN

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   retire_rec_t      rec_a_s, rec_b_s, first_s, second_s, head_s;
   retire_rec_t      wr0_data_s, wr1_data_s;
   retire_rec_t      rec_d, rec_q;
   logic             acc_a_s, acc_b_s, have_first_s, have_second_s;
   logic             empty_s, pop_s, req0_s, req1_s;
   logic             wr0_en_s, wr1_en_s, ovf_s, ovf_q;
   logic [CNT_W-1:0] count_s, free_s;

   // Filter events and order the accepted ones: A always precedes B.
   always_comb begin
      rec_a_s       = make_rec(wb_a_pc, wb_a_waddr, wb_a_wdata);
      rec_b_s       = make_rec(wb_b_pc, wb_b_waddr, wb_b_wdata);
      acc_a_s       = wb_a_valid && (wb_a_waddr != 5'd0);
      acc_b_s       = wb_b_valid && (wb_b_waddr != 5'd0);
      have_first_s  = acc_a_s || acc_b_s;
      have_second_s = acc_a_s && acc_b_s;
      second_s      = rec_b_s;
      if (acc_a_s) begin
         first_s = rec_a_s;
      end else begin
         first_s = rec_b_s;
      end
   end

   // Choose the output record, FIFO pushes and detect lost records.
   always_comb begin
      empty_s    = (count_s == {CNT_W{1'b0}});
      pop_s      = 1'b0;
      req0_s     = 1'b0;
      req1_s     = 1'b0;
      wr0_data_s = first_s;
      wr1_data_s = second_s;
      rec_d      = retire_rec_t'({RETIRE_W{1'b0}});
      if (!empty_s) begin
         // Buffered records go out first; everything accepted is queued.
         pop_s  = 1'b1;
         rec_d  = head_s;
         req0_s = have_first_s;
         req1_s = have_second_s;
      end else if (have_first_s) begin
         // Empty FIFO: bypass the first event, queue the second if present.
         rec_d      = first_s;
         req0_s     = have_second_s;
         wr0_data_s = second_s;
      end else begin
         rec_d = retire_rec_t'({RETIRE_W{1'b0}});
      end
      // The pop frees its slot before pushes are placed. Later records
      // (B before A) are the ones dropped when space runs out.
      free_s   = CNT_W'(FIFO_DEPTH) - count_s + {{(CNT_W-1){1'b0}}, pop_s};
      wr0_en_s = req0_s && (free_s != {CNT_W{1'b0}});
      wr1_en_s = req1_s && (free_s > {{(CNT_W-1){1'b0}}, 1'b1});
      ovf_s    = (req0_s && !wr0_en_s) || (req1_s && !wr1_en_s);
   end

   // Output record and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rec_q <= retire_rec_t'({RETIRE_W{1'b0}});
         ovf_q <= 1'b0;
      end else begin
         rec_q <= rec_d;
         ovf_q <= ovf_q || ovf_s;
      end
   end

   retire_fifo #(
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .wr0_en_i   (wr0_en_s),
      .wr0_data_i (wr0_data_s),
      .wr1_en_i   (wr1_en_s),
      .wr1_data_i (wr1_data_s),
      .rd_en_i    (pop_s),
      .rd_data_o  (head_s),
      .count_o    (count_s)
   );

   assign inst_retire  = rec_q;
   assign retire_stall = (count_s >= CNT_W'(FIFO_DEPTH - 1));
   assign overflow_err = ovf_q;

`else

   localparam int unused_depth = FIFO_DEPTH;
   logic unused_inputs_s;

   assign unused_inputs_s = ^{clk, rst,
                              wb_a_valid, wb_a_pc, wb_a_waddr, wb_a_wdata,
                              wb_b_valid, wb_b_pc, wb_b_waddr, wb_b_wdata};

   assign inst_retire  = {RETIRE_W{1'b0}};
   assign retire_stall = 1'b0;
   assign overflow_err = 1'b0;

`endif

endmodule

// File: tb/tb_retire_trace_gen.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_gen
// Directed and random stimulus for retire_trace_gen (FIFO_DEPTH=4) checked
// against a queue-based reference model. With RETIRE_TRACE_EN undefined the
// model expects every output to stay 0.
// -----------------------------------------------------------------------------
module tb_retire_trace_gen;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_a_valid, wb_b_valid;
   logic [31:0] wb_a_pc, wb_a_wdata, wb_b_pc, wb_b_wdata;
   logic [4:0]  wb_a_waddr, wb_b_waddr;
   logic [69:0] inst_retire;
   logic        retire_stall, overflow_err;

   int          tests = 0;
   int          fails = 0;
   logic [69:0] mq[$];
   logic [69:0] exp_out = 70'd0;
   logic        exp_ovf = 1'b0;

   always #5 clk = ~clk;

   retire_trace_gen #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_a_valid   (wb_a_valid),
      .wb_a_pc      (wb_a_pc),
      .wb_a_waddr   (wb_a_waddr),
      .wb_a_wdata   (wb_a_wdata),
      .wb_b_valid   (wb_b_valid),
      .wb_b_pc      (wb_b_pc),
      .wb_b_waddr   (wb_b_waddr),
      .wb_b_wdata   (wb_b_wdata),
      .inst_retire  (inst_retire),
      .retire_stall (retire_stall),
      .overflow_err (overflow_err)
   );

   function automatic logic [69:0] rec(input logic [31:0] pc,
                                       input logic [4:0] wa,
                                       input logic [31:0] wd);
      return {1'b1, wa, wd, pc};
   endfunction

   // Reference behaviour at one rising edge, from the current inputs.
   task automatic model_edge();
`ifdef RETIRE_TRACE_EN
      logic [69:0] acc[$];
      if (rst) begin
         mq.delete();
         exp_out = 70'd0;
         exp_ovf = 1'b0;
      end else begin
         if (wb_a_valid && wb_a_waddr != 5'd0) acc.push_back(rec(wb_a_pc, wb_a_waddr, wb_a_wdata));
         if (wb_b_valid && wb_b_waddr != 5'd0) acc.push_back(rec(wb_b_pc, wb_b_waddr, wb_b_wdata));
         if (mq.size() != 0) exp_out = mq.pop_front();
         else if (acc.size() != 0) exp_out = acc.pop_front();
         else exp_out = 70'd0;
         foreach (acc[i]) begin
            if (mq.size() < DEPTH) mq.push_back(acc[i]);
            else exp_ovf = 1'b1;
         end
      end
`else
      exp_out = 70'd0;
      exp_ovf = 1'b0;
`endif
   endtask

   task automatic check(input string tag);
      logic exp_stall;
`ifdef RETIRE_TRACE_EN
      exp_stall = (mq.size() >= DEPTH - 1);
`else
      exp_stall = 1'b0;
`endif
      tests++;
      assert (inst_retire === exp_out) else begin
         fails++;
         $error("FAIL %s inst_retire observed=%h expected=%h", tag, inst_retire, exp_out);
      end
      tests++;
      assert (retire_stall === exp_stall) else begin
         fails++;
         $error("FAIL %s retire_stall observed=%b expected=%b", tag, retire_stall, exp_stall);
      end
      tests++;
      assert (overflow_err === exp_ovf) else begin
         fails++;
         $error("FAIL %s overflow_err observed=%b expected=%b", tag, overflow_err, exp_ovf);
      end
   endtask

   task automatic cycle(input string tag, input logic r,
                        input logic av, input logic [31:0] apc, input logic [4:0] awa, input logic [31:0] awd,
                        input logic bv, input logic [31:0] bpc, input logic [4:0] bwa, input logic [31:0] bwd);
      rst        = r;
      wb_a_valid = av; wb_a_pc = apc; wb_a_waddr = awa; wb_a_wdata = awd;
      wb_b_valid = bv; wb_b_pc = bpc; wb_b_waddr = bwa; wb_b_wdata = bwd;
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0);
   endtask

   task automatic dual(input string tag, input int k);
      cycle(tag, 1'b0, 1'b1, 32'h1000 + 32'(k * 8), 5'd3, 32'hA000 + 32'(k),
                       1'b1, 32'h1004 + 32'(k * 8), 5'd4, 32'hB000 + 32'(k));
   endtask

   task automatic reset_cycle(input string tag);
      cycle(tag, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 32'd0);
   endtask

   task automatic expect_vec(input string tag, input logic [69:0] obs, input logic [69:0] req);
      tests++;
      assert (obs === req) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req);
      end
   endtask

   initial begin
      logic [69:0] v;
      reset_cycle("reset0");
      reset_cycle("reset1");

      // Single A event with an empty FIFO
      cycle("single_a", 1'b0, 1'b1, 32'h10, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 5'd0, 32'd0);
`ifdef RETIRE_TRACE_EN
      v = {1'b1, 5'd5, 32'hDEADBEEF, 32'h10};
      expect_vec("single_a_exact", inst_retire, v);
`endif
      idle("single_a_after");
      expect_vec("single_a_zero", inst_retire, 70'd0);

      // A and B together: A first, B one cycle later
      cycle("dual_ab", 1'b0, 1'b1, 32'h20, 5'd1, 32'h11, 1'b1, 32'h24, 5'd2, 32'h22);
`ifdef RETIRE_TRACE_EN
      expect_vec("dual_ab_pc_a", {38'd0, inst_retire[31:0]}, 70'h20);
`endif
      idle("dual_ab_n2");
`ifdef RETIRE_TRACE_EN
      expect_vec("dual_ab_pc_b", {38'd0, inst_retire[31:0]}, 70'h24);
`endif
      idle("dual_ab_n3");

      // waddr=0 is filtered without error
      cycle("waddr0", 1'b0, 1'b1, 32'h30, 5'd0, 32'h33, 1'b0, 32'h34, 5'd7, 32'h44);
      idle("waddr0_after");
      expect_vec("waddr0_zero", inst_retire, 70'd0);

      // Dual events every cycle: stall at count 3, then overflow dropping B
      for (int k = 0; k < 6; k++) begin
         dual("fill", k);
`ifdef RETIRE_TRACE_EN
         if (k == 2) expect_vec("stall_at_3", {69'd0, retire_stall}, 70'd1);
         if (k == 4) expect_vec("ovf_set", {69'd0, overflow_err}, 70'd1);
`endif
      end
      for (int k = 0; k < 6; k++) idle("drain");

      // Reset with three records buffered
      reset_cycle("clr_ovf");
      for (int k = 0; k < 3; k++) dual("refill", 10 + k);
      cycle("mid_reset", 1'b1, 1'b1, 32'h500, 5'd9, 32'h5, 1'b1, 32'h504, 5'd10, 32'h6);
      expect_vec("mid_reset_zero", inst_retire, 70'd0);
      for (int k = 0; k < 4; k++) idle("post_reset");
      expect_vec("post_reset_zero", inst_retire, 70'd0);

      // Random traffic with occasional resets
      for (int k = 0; k < 400; k++) begin
         cycle("random", 1'($urandom_range(0, 59) == 0),
               1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 2) != 0), $urandom, 5'($urandom_range(0, 7)), $urandom);
      end
      for (int k = 0; k < 6; k++) idle("final_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
